lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store unit controller between the core's memory-stage request and a word-organised data memory with a req/ack handshake. It decodes each load/store instruction, generates per-beat byte enables and lane-shifted write data, and splits misaligned accesses into two word beats. It merges and sign- or zero-extends load data and returns one response per accepted request.

## Interface
Parameters:
- `WIDTH`, default 32: data and address width; only 32 is supported.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: controller idle; a request is accepted when `req_valid && req_ready`.
- `inst`, in, 32: instruction; opcode is `inst[6:0]`, funct3 is `inst[14:12]`.
- `addr`, in, 32: effective byte address.
- `wdata`, in, 32: store data, right-aligned.
- `resp_valid`, out, 1: one-cycle response pulse.
- `resp_rdata`, out, 32: extended load result; 0 for stores and errors.
- `resp_err`, out, 1: illegal opcode/funct3; valid with `resp_valid`.
- `mem_req`, out, 1: memory beat request.
- `mem_we`, out, 1: beat is a write.
- `mem_addr`, out, 32: word-aligned beat address.
- `mem_be`, out, 4: byte enables; bit i selects byte lane i.
- `mem_wdata`, out, 32: lane-shifted write data.
- `mem_ack`, in, 1: beat complete.
- `mem_rdata`, in, 32: read word, valid in the ack cycle.

## Operation
- On accept, latch opcode, funct3, `addr` and `wdata`; later changes on the request inputs are ignored.
- Legal loads (opcode 0000011): funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores (opcode 0100011): funct3 000 SB, 001 SH, 010 SW.
- Anything else is an error: no memory beat, `resp_err`=1, `resp_rdata`=0.
- Access size is 1, 2 or 4 bytes; off = `addr[1:0]`; mask = 2^size − 1 (4 bits); M = mask << off (8 bits).
- A split is needed when off + size > 4.
- Beat 0:
  - `mem_addr` = `{addr[31:2],2'b00}`.
  - `mem_be` = M[3:0].
  - `mem_wdata` = bits [31:0] of the 64-bit value `wdata` << 8·off.
- Beat 1 (split only):
  - `mem_addr` = beat-0 address + 4, wrapping modulo 2^32.
  - `mem_be` = M[7:4].
  - `mem_wdata` = bits [63:32] of the same shifted value.
- `mem_we` = 1 for stores.
- Loads: capture `mem_rdata` on each ack into a 64-bit buffer {beat1, beat0}; beat1 is 0 if there is no split.
  - Shift the buffer right by 8·off and keep the low size bytes.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- FSM states:
  - IDLE: `req_ready`=1. On a legal accept go to BEAT0; on an illegal accept go to RESP with err set.
  - BEAT0: `mem_req`=1. On `mem_ack`, go to BEAT1 if split, else RESP.
  - BEAT1: `mem_req`=1. On `mem_ack`, go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- `mem_req`, `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are stable from the first request cycle until the ack cycle inclusive.
- An ack in the first cycle of `mem_req` counts.
- Minimum latency from accept edge to `resp_valid`: 2 cycles aligned, 3 split, 1 error.
- `resp_rdata` and `resp_err` are registered and held until the next response; outside RESP they are don't-care.
- `req_ready`=0 in BEAT0, BEAT1 and RESP; no back-to-back accept in RESP.
- Reset values: state IDLE, `req_ready`=1, and all other outputs 0.
- Reset mid-operation: outputs return to reset values asynchronously (`mem_req` drops in the same cycle). The beat is abandoned, no response is issued, and a late `mem_ack` is ignored.

## Structure
- Package `lsu_pkg` holds:
  - FSM state enum `lsu_state_t` (IDLE, BEAT0, BEAT1, RESP).
  - Opcode constants `OP_LOAD`, `OP_STORE`.
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Size type `lsu_size_t`.
- One combinational sub-module, `lsu_align`, computes byte-enable masks, the 64-bit write-lane shift and load extract/extension from size, off, sign flag and the buffer.
- `lsu_ctrl` contains the FSM, request latches and read buffer.

## Test plan
- LB at 0x103, `mem_rdata`=0x80FF1234, ack in the first cycle -> one beat with addr 0x100, be 1000, we 0; `resp_rdata`=0xFFFFFF80, two cycles after accept.
- LBU at 0x103 with the same data -> `resp_rdata`=0x00000080.
- SH at 0x102, `wdata`=0x0000ABCD -> one beat with addr 0x100, be 1100, `mem_wdata`=0xABCD0000, we 1; `resp_rdata`=0.
- LW at 0x201 -> beat 0: addr 0x200, be 1110, rdata 0x44332211; beat 1: addr 0x204, be 0001, rdata 0x88776655; result 0x55443322, three cycles after accept.
- SW at 0x203 with 3-cycle ack delay per beat -> request fields stable while `mem_req`=1 and `req_ready`=0 throughout. Beat 0: be 1000, `mem_wdata`=wdata<<24. Beat 1: be 0111. `resp_valid` is high one cycle only.
- Load with funct3 011 -> no `mem_req`; `resp_valid` with `resp_err`=1 one cycle after accept.
- Assert `rst_n`=0 during BEAT1 -> `mem_req`=0 immediately; after release `req_ready`=1 and no `resp_valid` appears.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
// Holds the FSM state encoding, opcode/funct3 values and decode helpers.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (op == OP_LOAD)
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
      else if (op == OP_STORE)
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return ok;
   endfunction

   // funct3[1:0] encodes the access size for both loads and stores.
   function automatic lsu_size_t f3_size(input logic [2:0] f3);
      lsu_size_t sz;
      case (f3[1:0])
         2'b00:   sz = SZ_BYTE;
         2'b01:   sz = SZ_HALF;
         default: sz = SZ_WORD;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: byte-enable masks for both beats,
// store-data lane shift and load-data extract with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  lsu_size_t   size,
   input  logic [1:0]  off,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [63:0] rbuf,
   output logic [3:0]  be0,
   output logic [3:0]  be1,
   output logic        split,
   output logic [31:0] wdata0,
   output logic [31:0] wdata1,
   output logic [31:0] rdata
);

   logic [3:0]  mask;
   logic [7:0]  lane_mask;
   logic [63:0] wshift;
   logic [31:0] rlow;

   function automatic logic [31:0] extend(input logic [31:0] v, input lsu_size_t sz,
                                          input logic sx);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = v[7:0];
      h = v[15:0];
      case (sz)
         SZ_BYTE: r = sx ? 32'(b) : {24'h0, v[7:0]};
         SZ_HALF: r = sx ? 32'(h) : {16'h0, v[15:0]};
         default: r = v;
      endcase
      return r;
   endfunction

   always_comb begin
      case (size)
         SZ_BYTE: mask = 4'b0001;
         SZ_HALF: mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
   end

   // Any enable that spills past lane 3 belongs to the following word.
   assign lane_mask = {4'h0, mask} << off;
   assign be0       = lane_mask[3:0];
   assign be1       = lane_mask[7:4];
   assign split     = |lane_mask[7:4];

   assign wshift = {32'h0, wdata} << {off, 3'b000};
   assign wdata0 = wshift[31:0];
   assign wdata1 = wshift[63:32];

   assign rlow  = 32'(rbuf >> {off, 3'b000});
   assign rdata = extend(rlow, size, sign_ext);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory-stage request at a time,
// issues one or two word beats over req/ack and returns a single response.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      inst,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [3:0]       mem_be,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata
);

   lsu_state_t  state, state_nxt;
   logic [6:0]  op_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, rbuf0_q;
   logic [31:0] base;
   logic [63:0] rbuf;
   logic        accept, legal_in, is_store, split, last_ack;
   logic [3:0]  be0, be1;
   logic [31:0] wdata0, wdata1, ld_data;
   logic        unused_inst_bits;

   assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

   assign accept   = req_valid && (state == IDLE);
   assign legal_in = is_legal(inst[6:0], inst[14:12]);
   assign is_store = (op_q == OP_STORE);
   assign base     = {addr_q[31:2], 2'b00};

   // The final beat's word comes straight from mem_rdata in its ack cycle.
   assign rbuf = (state == BEAT1) ? {mem_rdata, rbuf0_q} : {32'h0, mem_rdata};

   lsu_align u_align (
      .size     (f3_size(f3_q)),
      .off      (addr_q[1:0]),
      .sign_ext (~f3_q[2]),
      .wdata    (wdata_q),
      .rbuf     (rbuf),
      .be0      (be0),
      .be1      (be1),
      .split    (split),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .rdata    (ld_data)
   );

   assign last_ack = mem_ack && (((state == BEAT0) && !split) || (state == BEAT1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = legal_in ? BEAT0 : RESP;
         BEAT0:   if (mem_ack) state_nxt = split ? BEAT1 : RESP;
         BEAT1:   if (mem_ack) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_be     = '0;
      mem_wdata  = '0;
      case (state)
         IDLE: req_ready = 1'b1;
         BEAT0: begin
            mem_req   = 1'b1;
            mem_we    = is_store;
            mem_addr  = base;
            mem_be    = be0;
            mem_wdata = wdata0;
         end
         BEAT1: begin
            mem_req   = 1'b1;
            mem_we    = is_store;
            mem_addr  = base + 32'd4;
            mem_be    = be1;
            mem_wdata = wdata1;
         end
         RESP:    resp_valid = 1'b1;
         default: req_ready = 1'b0;
      endcase
   end

   // Request fields and the first read word need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q    <= inst[6:0];
         f3_q    <= inst[14:12];
         addr_q  <= addr;
         wdata_q <= wdata;
      end
      if ((state == BEAT0) && mem_ack)
         rbuf0_q <= mem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else if (accept && !legal_in) begin
         resp_err   <= 1'b1;
         resp_rdata <= '0;
      end else if (last_ack) begin
         resp_err   <= 1'b0;
         resp_rdata <= is_store ? 32'h0 : ld_data;
      end
   end

endmodule
